// File: rtl/branch_update_buffer.sv
// branch_update_buffer: buffers resolved conditional-branch outcomes until commit,
// then emits at most one registered predictor update per cycle in arrival order.
module branch_update_buffer #(
  parameter int NUM_IN = 2,
  parameter int SIZE   = 16,
  parameter int ID_LEN = 7,
  parameter int FID_W  = 5,
  parameter int OFF_W  = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_IN-1:0]              i_br_valid,
  input  logic [NUM_IN-1:0][ID_LEN-1:0]  i_br_sqn,
  input  logic [NUM_IN-1:0][FID_W-1:0]   i_br_fetch_id,
  input  logic [NUM_IN-1:0][OFF_W-1:0]   i_br_fetch_offs,
  input  logic [NUM_IN-1:0]              i_br_taken,
  input  logic [NUM_IN-1:0]              i_br_is_regular,
  input  logic [ID_LEN-1:0]              i_com_sqn,
  input  logic                           i_flush,
  input  logic [ID_LEN-1:0]              i_flush_sqn,
  output logic                           o_stall,
  output logic                           o_bp_valid,
  output logic [FID_W-1:0]               o_bp_fetch_id,
  output logic [OFF_W-1:0]               o_bp_fetch_offs,
  output logic                           o_bp_taken
);
  localparam int PW = $clog2(SIZE);
  localparam int CW = PW + 1;

  function automatic logic f_older(input logic [ID_LEN-1:0] a, input logic [ID_LEN-1:0] b);
    logic [ID_LEN-1:0] d;
    d = a - b;
    return d[ID_LEN-1];
  endfunction

  function automatic logic f_younger(input logic [ID_LEN-1:0] a, input logic [ID_LEN-1:0] b);
    logic [ID_LEN-1:0] d;
    d = a - b;
    return !d[ID_LEN-1] && d != '0;
  endfunction

  logic [SIZE-1:0]   r_valid;
  logic [ID_LEN-1:0] r_sqn  [SIZE];
  logic [FID_W-1:0]  r_fid  [SIZE];
  logic [OFF_W-1:0]  r_offs [SIZE];
  logic [SIZE-1:0]   r_taken;
  logic [PW-1:0]     r_head, r_tail;
  logic [CW-1:0]     r_count;
  logic              r_bp_valid;
  logic [FID_W-1:0]  r_bp_fid;
  logic [OFF_W-1:0]  r_bp_offs;
  logic              r_bp_taken;

  logic [NUM_IN-1:0] w_acc;
  logic [PW-1:0]     w_wr_idx [NUM_IN];
  logic [CW-1:0]     w_n_acc;
  logic              w_upd, w_deq;

  // Accepted inputs pack densely from tail in port order.
  always_comb begin
    w_n_acc = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      w_acc[i] = i_br_valid[i] && i_br_is_regular[i] && !(i_flush && f_younger(i_br_sqn[i], i_flush_sqn));
      w_wr_idx[i] = r_tail + w_n_acc[PW-1:0];
      w_n_acc = w_n_acc + CW'(w_acc[i]);
    end
  end

  // Invalidated heads are reclaimed without an update; valid heads wait for commit.
  assign w_upd = r_count != '0 && r_valid[r_head] && f_older(r_sqn[r_head], i_com_sqn)
                 && !(i_flush && f_younger(r_sqn[r_head], i_flush_sqn));
  assign w_deq = r_count != '0 && (!r_valid[r_head] || w_upd);
  assign o_stall = !rst || (CW'(SIZE) - r_count) < CW'(NUM_IN);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid    <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_bp_valid <= 1'b0;
      r_bp_fid   <= '0;
      r_bp_offs  <= '0;
      r_bp_taken <= 1'b0;
    end else begin
      for (int j = 0; j < SIZE; j++)
        if (i_flush && f_younger(r_sqn[j], i_flush_sqn)) r_valid[j] <= 1'b0;
      for (int i = 0; i < NUM_IN; i++)
        if (w_acc[i]) begin
          r_valid[w_wr_idx[i]] <= 1'b1;
          r_sqn[w_wr_idx[i]]   <= i_br_sqn[i];
          r_fid[w_wr_idx[i]]   <= i_br_fetch_id[i];
          r_offs[w_wr_idx[i]]  <= i_br_fetch_offs[i];
          r_taken[w_wr_idx[i]] <= i_br_taken[i];
        end
      r_head     <= w_deq ? r_head + 1'b1 : r_head;
      r_tail     <= r_tail + w_n_acc[PW-1:0];
      r_count    <= r_count + w_n_acc - CW'(w_deq);
      r_bp_valid <= w_upd;
      if (w_upd) begin
        r_bp_fid   <= r_fid[r_head];
        r_bp_offs  <= r_offs[r_head];
        r_bp_taken <= r_taken[r_head];
      end
    end
  end

  assign o_bp_valid      = r_bp_valid;
  assign o_bp_fetch_id   = r_bp_fid;
  assign o_bp_fetch_offs = r_bp_offs;
  assign o_bp_taken      = r_bp_taken;
endmodule

// File: tb/tb_branch_update_buffer.sv
// tb_branch_update_buffer: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a queue-based reference model.
module tb_branch_update_buffer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0]      bv = '0, breg = '0, btk = '0;
  logic [1:0][6:0] bsqn = '0;
  logic [1:0][4:0] bfid = '0;
  logic [1:0][2:0] boffs = '0;
  logic [6:0]      com = '0, fsq = '0;
  logic            flush = 1'b0;
  logic            o_stall, o_bp_valid, o_bp_taken;
  logic [4:0]      o_bp_fetch_id;
  logic [2:0]      o_bp_fetch_offs;
  int              total = 0, bad = 0;

  branch_update_buffer dut (
    .clk(clk), .rst(rst),
    .i_br_valid(bv), .i_br_sqn(bsqn), .i_br_fetch_id(bfid), .i_br_fetch_offs(boffs),
    .i_br_taken(btk), .i_br_is_regular(breg),
    .i_com_sqn(com), .i_flush(flush), .i_flush_sqn(fsq),
    .o_stall(o_stall), .o_bp_valid(o_bp_valid), .o_bp_fetch_id(o_bp_fetch_id),
    .o_bp_fetch_offs(o_bp_fetch_offs), .o_bp_taken(o_bp_taken)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [6:0] sqn;
    logic [4:0] fid;
    logic [2:0] offs;
    logic       tk;
  } ent_t;

  ent_t       q[$];
  logic       ev = 1'b0, etk = 1'b0;
  logic [4:0] efid = '0;
  logic [2:0] eoffs = '0;

  // Signed 7-bit distance a-b with wrap-around: <0 means a is older than b.
  function automatic int age(input logic [6:0] a, input logic [6:0] b);
    logic [6:0] d;
    d = a - b;
    return $signed(d);
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic model_step;
    ent_t e;
    ev = 1'b0;
    if (!rst) q.delete();
    else begin
      if (q.size() > 0) begin
        if (!q[0].v) void'(q.pop_front());
        else if (age(q[0].sqn, com) < 0 && !(flush && age(q[0].sqn, fsq) > 0)) begin
          ev = 1'b1; efid = q[0].fid; eoffs = q[0].offs; etk = q[0].tk;
          void'(q.pop_front());
        end
      end
      if (flush) foreach (q[k]) if (age(q[k].sqn, fsq) > 0) q[k].v = 1'b0;
      for (int i = 0; i < 2; i++)
        if (bv[i] && breg[i] && !(flush && age(bsqn[i], fsq) > 0)) begin
          total++;
          if (q.size() >= 16) begin
            bad++;
            $display("FAIL overflow got=%0d entries expected<16 at %0t", q.size(), $time);
          end else begin
            e.v = 1'b1; e.sqn = bsqn[i]; e.fid = bfid[i]; e.offs = boffs[i]; e.tk = btk[i];
            q.push_back(e);
          end
        end
    end
  endtask

  always @(posedge clk) begin
    model_step();
    #2;
    chk("stall", o_stall, (!rst || (16 - q.size()) < 2) ? 1 : 0);
    chk("bp_valid", o_bp_valid, ev);
    if (ev) begin
      chk("bp_fetch_id", o_bp_fetch_id, efid);
      chk("bp_fetch_offs", o_bp_fetch_offs, eoffs);
      chk("bp_taken", o_bp_taken, etk);
    end
  end

  task automatic idle;
    bv = '0; breg = '0; flush = 1'b0;
  endtask

  task automatic put(input int p, input logic [6:0] s, input logic [2:0] o, input logic t);
    bv[p] = 1'b1; breg[p] = 1'b1; bsqn[p] = s; bfid[p] = s[4:0]; boffs[p] = o; btk[p] = t;
  endtask

  task automatic nxt;
    @(negedge clk);
  endtask

  initial begin
    logic [6:0] seq;
    int span;
    repeat (3) nxt;
    chk("lit_rst_stall", o_stall, 1);
    chk("lit_rst_valid", o_bp_valid, 0);
    rst = 1'b1;
    nxt;
    chk("lit_stall_after_rst", o_stall, 0);
    // single committed branch: 2-cycle latency
    com = 10;
    put(0, 5, 2, 1); bfid[0] = 3;
    nxt; idle;
    chk("lit_single_early", o_bp_valid, 0);
    nxt;
    chk("lit_single_valid", o_bp_valid, 1);
    chk("lit_single_fid", o_bp_fetch_id, 3);
    chk("lit_single_offs", o_bp_fetch_offs, 2);
    chk("lit_single_taken", o_bp_taken, 1);
    nxt;
    chk("lit_single_after", o_bp_valid, 0);
    // dual port, same cycle
    com = 30;
    put(0, 20, 1, 0); put(1, 21, 5, 1);
    nxt; idle;
    chk("lit_dual_early", o_bp_valid, 0);
    nxt;
    chk("lit_dual0_fid", o_bp_fetch_id, 20);
    chk("lit_dual0_taken", o_bp_taken, 0);
    nxt;
    chk("lit_dual1_fid", o_bp_fetch_id, 21);
    chk("lit_dual1_offs", o_bp_fetch_offs, 5);
    nxt;
    chk("lit_dual_after", o_bp_valid, 0);
    // commit gating across the 7-bit wrap
    com = 125;
    put(0, 126, 0, 1); put(1, 1, 0, 0);
    nxt; idle;
    repeat (3) begin nxt; chk("lit_wrap_hold", o_bp_valid, 0); end
    com = 127;
    nxt;
    chk("lit_wrap126_valid", o_bp_valid, 1);
    chk("lit_wrap126_fid", o_bp_fetch_id, 126 % 32);
    nxt;
    chk("lit_wrap1_wait", o_bp_valid, 0);
    com = 2;
    nxt;
    chk("lit_wrap1_valid", o_bp_valid, 1);
    chk("lit_wrap1_fid", o_bp_fetch_id, 1);
    nxt;
    // flush: 32 dropped, 29 kept, 33 squashed into a bubble
    com = 28;
    put(0, 30, 0, 0); put(1, 31, 0, 1);
    nxt; idle;
    put(0, 33, 0, 0);
    nxt; idle;
    flush = 1'b1; fsq = 31;
    put(0, 32, 0, 0); put(1, 29, 0, 1);
    nxt; idle;
    com = 40;
    nxt; chk("lit_flush_30", o_bp_fetch_id, 30); chk("lit_flush_30v", o_bp_valid, 1);
    nxt; chk("lit_flush_31", o_bp_fetch_id, 31); chk("lit_flush_31v", o_bp_valid, 1);
    nxt; chk("lit_flush_bubble", o_bp_valid, 0);
    nxt; chk("lit_flush_29", o_bp_fetch_id, 29); chk("lit_flush_29v", o_bp_valid, 1);
    nxt; chk("lit_flush_done", o_bp_valid, 0);
    // full and stall, with pointer wrap
    com = 50;
    for (int k = 0; k < 7; k++) begin
      put(0, 7'(60 + 2 * k), 0, 0); put(1, 7'(61 + 2 * k), 0, 1);
      nxt; idle;
    end
    put(0, 74, 0, 0);
    nxt; idle;
    chk("lit_full15_stall", o_stall, 1);
    com = 61;
    nxt;
    chk("lit_free_stall", o_stall, 0);
    chk("lit_free_fid", o_bp_fetch_id, 60 % 32);
    put(0, 75, 0, 0); put(1, 76, 0, 1);
    nxt; idle;
    chk("lit_full16_stall", o_stall, 1);
    com = 100;
    for (int k = 0; k < 16; k++) begin
      nxt;
      chk("lit_drain_fid", o_bp_fetch_id, (61 + k) % 32);
    end
    nxt;
    chk("lit_drain_end", o_bp_valid, 0);
    // reset mid-operation discards pending entries
    for (int k = 0; k < 4; k++) begin
      put(0, 7'(110 + 2 * k), 0, 0); put(1, 7'(111 + 2 * k), 0, 1);
      nxt; idle;
    end
    com = 120; rst = 1'b0;
    nxt;
    chk("lit_midrst_stall", o_stall, 1);
    rst = 1'b1;
    repeat (12) begin
      nxt;
      chk("lit_postrst_valid", o_bp_valid, 0);
      chk("lit_postrst_stall", o_stall, 0);
    end
    // randomized phase
    seq = com;
    for (int c = 0; c < 3000; c++) begin
      idle;
      rst = ($urandom_range(0, 299) != 0);
      if (seq != com && $urandom_range(0, 1) != 0) com = com + 1;
      span = int'(7'(seq - com));
      if ($urandom_range(0, 15) == 0) begin
        flush = 1'b1;
        fsq = com + 7'($urandom_range(0, span + 2));
      end
      if (!o_stall && span < 40)
        for (int p = 0; p < 2; p++)
          if ($urandom_range(0, 2) != 0) begin
            bv[p] = 1'b1;
            breg[p] = ($urandom_range(0, 3) != 0);
            bsqn[p] = seq;
            bfid[p] = 5'($urandom);
            boffs[p] = 3'($urandom);
            btk[p] = 1'($urandom);
            seq = seq + 1;
          end
      if (flush && age(fsq + 1, com) >= 0) seq = fsq + 1;
      nxt;
    end
    idle; rst = 1'b1; com = seq;
    repeat (40) nxt;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
